// File: rtl/instruction_set.sv
// Shared encodings between the memory access unit and the data-memory responder.
package instruction_set;

   localparam int unsigned WORD_SIZE = 8;

   typedef enum logic [1:0] {
      MEM_NOP   = 2'd0,
      MEM_READ  = 2'd1,
      MEM_WRITE = 2'd2
   } mem_op_e;

   typedef enum logic [1:0] {
      REQ_LOAD  = 2'd0,
      REQ_STORE = 2'd1,
      REQ_COPY  = 2'd2,
      REQ_FILL  = 2'd3
   } req_kind_e;

endpackage

// File: rtl/mem_access_unit.sv
// Sequences single-word load/store and multi-word copy/fill transfers onto a
// data-memory port; one request in flight, completion reported by a one-cycle pulse.
module mem_access_unit
   import instruction_set::*;
#(
   parameter int unsigned WORD_SIZE = instruction_set::WORD_SIZE
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_kind,
   input  logic [WORD_SIZE-1:0] req_addr,
   input  logic [WORD_SIZE-1:0] req_src,
   input  logic [WORD_SIZE-1:0] req_data,
   input  logic [WORD_SIZE-1:0] req_len,
   output logic                 resp_valid,
   output logic [WORD_SIZE-1:0] resp_data,
   output logic                 busy,
   output logic [1:0]           mem_op,
   output logic [WORD_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0] mem_write_data,
   input  logic [WORD_SIZE-1:0] mem_read_data
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      STORE   = 3'd2,
      COPY_RD = 3'd3,
      COPY_WR = 3'd4,
      FILL    = 3'd5,
      DONE    = 3'd6
   } state_e;

   state_e               r_state,   w_state_n;
   logic [WORD_SIZE-1:0] r_addr,    w_addr_n;
   logic [WORD_SIZE-1:0] r_src,     w_src_n;
   logic [WORD_SIZE-1:0] r_data,    w_data_n;
   logic [WORD_SIZE-1:0] r_len,     w_len_n;
   logic [WORD_SIZE-1:0] r_idx,     w_idx_n;
   logic [WORD_SIZE-1:0] r_buf,     w_buf_n;
   logic [WORD_SIZE-1:0] r_result,  w_result_n;

   // Registered port outputs, computed from the next state so they line up with it.
   logic                 r_req_ready,  w_req_ready_n;
   logic                 r_busy,       w_busy_n;
   logic                 r_resp_valid, w_resp_valid_n;
   logic [WORD_SIZE-1:0] r_resp_data,  w_resp_data_n;
   mem_op_e              r_mem_op,     w_mem_op_n;
   logic [WORD_SIZE-1:0] r_mem_addr,   w_mem_addr_n;
   logic [WORD_SIZE-1:0] r_mem_wdata,  w_mem_wdata_n;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_addr       <= '0;
         r_src        <= '0;
         r_data       <= '0;
         r_len        <= '0;
         r_idx        <= '0;
         r_buf        <= '0;
         r_result     <= '0;
         r_req_ready  <= 1'b1;
         r_busy       <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
         r_mem_op     <= MEM_NOP;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
      end else begin
         r_state      <= w_state_n;
         r_addr       <= w_addr_n;
         r_src        <= w_src_n;
         r_data       <= w_data_n;
         r_len        <= w_len_n;
         r_idx        <= w_idx_n;
         r_buf        <= w_buf_n;
         r_result     <= w_result_n;
         r_req_ready  <= w_req_ready_n;
         r_busy       <= w_busy_n;
         r_resp_valid <= w_resp_valid_n;
         r_resp_data  <= w_resp_data_n;
         r_mem_op     <= w_mem_op_n;
         r_mem_addr   <= w_mem_addr_n;
         r_mem_wdata  <= w_mem_wdata_n;
      end
   end

   always_comb begin
      w_state_n  = r_state;
      w_addr_n   = r_addr;
      w_src_n    = r_src;
      w_data_n   = r_data;
      w_len_n    = r_len;
      w_idx_n    = r_idx;
      w_buf_n    = r_buf;
      w_result_n = r_result;

      unique case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_addr_n   = req_addr;
               w_src_n    = req_src;
               w_data_n   = req_data;
               w_len_n    = req_len;
               w_idx_n    = '0;
               w_result_n = '0;
               unique case (req_kind)
                  2'(REQ_LOAD):  w_state_n = LOAD;
                  2'(REQ_STORE): w_state_n = STORE;
                  2'(REQ_COPY): begin
                     w_result_n = req_len;
                     w_state_n  = (req_len != '0) ? COPY_RD : DONE;
                  end
                  default: begin
                     w_result_n = req_len;
                     w_state_n  = (req_len != '0) ? FILL : DONE;
                  end
               endcase
            end
         end
         LOAD: begin
            w_result_n = mem_read_data;
            w_state_n  = DONE;
         end
         STORE: begin
            w_result_n = '0;
            w_state_n  = DONE;
         end
         COPY_RD: begin
            w_buf_n   = mem_read_data;
            w_state_n = COPY_WR;
         end
         COPY_WR: begin
            if (r_idx == r_len - WORD_SIZE'(1)) begin
               w_state_n = DONE;
            end else begin
               w_idx_n   = r_idx + WORD_SIZE'(1);
               w_state_n = COPY_RD;
            end
         end
         FILL: begin
            if (r_idx == r_len - WORD_SIZE'(1)) begin
               w_state_n = DONE;
            end else begin
               w_idx_n = r_idx + WORD_SIZE'(1);
            end
         end
         DONE:    w_state_n = IDLE;
         default: w_state_n = IDLE;
      endcase

      w_req_ready_n  = (w_state_n == IDLE);
      w_busy_n       = (w_state_n != IDLE);
      w_resp_valid_n = (w_state_n == DONE);
      w_resp_data_n  = (w_state_n == DONE) ? w_result_n : '0;
      w_mem_op_n     = MEM_NOP;
      w_mem_addr_n   = '0;
      w_mem_wdata_n  = '0;

      // Address sums are WORD_SIZE wide, so they wrap modulo 2^WORD_SIZE.
      unique case (w_state_n)
         LOAD: begin
            w_mem_op_n   = MEM_READ;
            w_mem_addr_n = w_addr_n;
         end
         STORE: begin
            w_mem_op_n    = MEM_WRITE;
            w_mem_addr_n  = w_addr_n;
            w_mem_wdata_n = w_data_n;
         end
         COPY_RD: begin
            w_mem_op_n   = MEM_READ;
            w_mem_addr_n = WORD_SIZE'(w_src_n + w_idx_n);
         end
         COPY_WR: begin
            w_mem_op_n    = MEM_WRITE;
            w_mem_addr_n  = WORD_SIZE'(w_addr_n + w_idx_n);
            w_mem_wdata_n = w_buf_n;
         end
         FILL: begin
            w_mem_op_n    = MEM_WRITE;
            w_mem_addr_n  = WORD_SIZE'(w_addr_n + w_idx_n);
            w_mem_wdata_n = w_data_n;
         end
         default: ;
      endcase
   end

   assign req_ready      = r_req_ready;
   assign busy           = r_busy;
   assign resp_valid     = r_resp_valid;
   assign resp_data      = r_resp_data;
   assign mem_op         = r_mem_op;
   assign mem_addr       = r_mem_addr;
   assign mem_write_data = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural responder memory.
module tb_mem_access_unit;
   import instruction_set::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_kind;
   logic [7:0] req_addr, req_src, req_data, req_len;
   logic       resp_valid;
   logic [7:0] resp_data;
   logic       busy;
   logic [1:0] mem_op;
   logic [7:0] mem_addr, mem_write_data, mem_read_data;

   logic [7:0] mem [256];
   logic       tb_we;
   logic [7:0] tb_addr, tb_data;
   int         wr_count  = 0;
   int         op_count  = 0;
   int         acc_count = 0;
   int         rsp_count = 0;
   int         n_tests   = 0;
   int         n_fail    = 0;
   int         cyc;

   mem_access_unit #(.WORD_SIZE(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
      .req_addr(req_addr), .req_src(req_src), .req_data(req_data), .req_len(req_len),
      .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
      .mem_op(mem_op), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   assign mem_read_data = mem[mem_addr];

   // Responder memory plus activity counters sampled at each rising edge.
   always @(posedge clk) begin
      if (tb_we) begin
         mem[tb_addr] <= tb_data;
      end else if (mem_op == 2'(MEM_WRITE)) begin
         mem[mem_addr] <= mem_write_data;
         wr_count      <= wr_count + 1;
      end
      if (mem_op != 2'(MEM_NOP)) op_count  <= op_count + 1;
      if (req_valid && req_ready) acc_count <= acc_count + 1;
      if (resp_valid)             rsp_count <= rsp_count + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      tb_we = 1'b1; tb_addr = a; tb_data = d;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   // Issue at a falling edge; returns at the falling edge of the first cycle after accept.
   task automatic send(input logic [1:0] k, input logic [7:0] a, input logic [7:0] s,
                       input logic [7:0] d, input logic [7:0] l);
      check("ready_before_send", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_kind = k; req_addr = a; req_src = s; req_data = d; req_len = l;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(input string tag, input int exp_lat, input logic [7:0] exp_data);
      int c;
      c = 1;
      while (!resp_valid && c < 40) begin
         @(negedge clk);
         c++;
      end
      check({tag, "_latency"}, 32'(c), 32'(exp_lat));
      check({tag, "_resp_data"}, 32'(resp_data), 32'(exp_data));
      @(negedge clk);
      check({tag, "_resp_clear"}, {23'd0, resp_valid, resp_data}, 32'd0);
   endtask

   initial begin
      int w0, o0, a0, r0;
      tb_we = 1'b0; tb_addr = '0; tb_data = '0;
      req_valid = 1'b0; req_kind = '0; req_addr = '0; req_src = '0; req_data = '0; req_len = '0;
      reset = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      repeat (2) @(negedge clk);
      check("reset_ready", 32'(req_ready), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_resp", {23'd0, resp_valid, resp_data}, 32'd0);
      check("reset_memop", 32'(mem_op), 32'(MEM_NOP));
      reset = 1'b1;
      @(negedge clk);

      // LOAD
      poke(8'h10, 8'h5A);
      send(2'(REQ_LOAD), 8'h10, 8'h00, 8'h00, 8'h00);
      check("load_op", {22'd0, mem_op, mem_addr}, {22'd0, 2'(MEM_READ), 8'h10});
      check("load_busy", {30'd0, busy, req_ready}, 32'd2);
      wait_resp("load", 2, 8'h5A);
      check("load_idle", {30'd0, busy, req_ready}, 32'd1);

      // STORE
      send(2'(REQ_STORE), 8'h33, 8'h00, 8'hC3, 8'h00);
      check("store_op", {14'd0, mem_op, mem_addr, mem_write_data}, {14'd0, 2'(MEM_WRITE), 8'h33, 8'hC3});
      wait_resp("store", 2, 8'h00);
      check("store_mem", 32'(mem[8'h33]), 32'hC3);

      // FILL with address wrap
      w0 = wr_count;
      send(2'(REQ_FILL), 8'hFE, 8'h00, 8'hAA, 8'd3);
      wait_resp("fill", 4, 8'd3);
      check("fill_mem", {8'd0, mem[8'hFE], mem[8'hFF], mem[8'h00]}, 32'h00AAAAAA);
      check("fill_writes", 32'(wr_count - w0), 32'd3);

      // COPY with a second request held through busy
      for (int i = 0; i < 4; i++) poke(8'(8'h20 + i), 8'(i + 1));
      a0 = acc_count;
      send(2'(REQ_COPY), 8'h40, 8'h20, 8'h00, 8'd4);
      req_valid = 1'b1; req_kind = 2'(REQ_STORE); req_addr = 8'h50; req_data = 8'h77; req_len = 8'd0;
      cyc = 1;
      while (!resp_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("copy_latency", 32'(cyc), 32'd9);
      check("copy_resp_data", 32'(resp_data), 32'd4);
      check("hold_not_accepted", 32'(acc_count - a0), 32'd1);
      check("copy_mem", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'h01020304);
      @(negedge clk);
      check("hold_idle_ready", 32'(req_ready), 32'd1);
      check("hold_still_one", 32'(acc_count - a0), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      check("hold_accepted", 32'(acc_count - a0), 32'd2);
      wait_resp("held_store", 2, 8'h00);
      check("held_store_mem", 32'(mem[8'h50]), 32'h77);
      check("held_once", 32'(acc_count - a0), 32'd2);

      // COPY of zero length touches no memory
      o0 = op_count;
      send(2'(REQ_COPY), 8'h40, 8'h20, 8'h00, 8'd0);
      check("len0_op", 32'(mem_op), 32'(MEM_NOP));
      wait_resp("copy_len0", 1, 8'd0);
      check("len0_no_access", 32'(op_count - o0), 32'd0);

      // Overlapping ascending copy smears the first word forward
      poke(8'h60, 8'h09);
      send(2'(REQ_COPY), 8'h61, 8'h60, 8'h00, 8'd3);
      wait_resp("overlap", 7, 8'd3);
      check("overlap_mem", {mem[8'h60], mem[8'h61], mem[8'h62], mem[8'h63]}, 32'h09090909);

      // Reset after the second FILL word
      w0 = wr_count; r0 = rsp_count;
      send(2'(REQ_FILL), 8'h80, 8'h00, 8'h55, 8'd5);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("abort_state", {28'd0, req_ready, busy, resp_valid, 1'b0}, 32'h8);
      check("abort_memop", 32'(mem_op), 32'(MEM_NOP));
      reset = 1'b1;
      repeat (6) @(negedge clk);
      check("abort_writes", 32'(wr_count - w0), 32'd2);
      check("abort_mem", {8'd0, mem[8'h80], mem[8'h81], mem[8'h82]}, 32'h00555500);
      check("abort_no_resp", 32'(rsp_count - r0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter WORD_SIZE, default from instruction_set, data/address width (8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset; sampled on clk rising edge.
REQ-004 SHALL have ports req_valid input 1, req_ready output 1: request handshake; transfer when both high on a rising edge.
REQ-005 SHALL have port req_kind  input  2  REQ_LOAD, REQ_STORE, REQ_COPY or REQ_FILL.
REQ-006 SHALL have ports req_addr, req_src, req_data, req_len  input  WORD_SIZE each: destination/load address, copy source, store/fill value, word count.
REQ-007 SHALL have ports resp_valid output 1, resp_data output WORD_SIZE: completion pulse and result.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have ports mem_op output 2, mem_addr output WORD_SIZE, mem_write_data output WORD_SIZE, mem_read_data input WORD_SIZE: initiator side of the data-memory port; read data is combinational in the same cycle as mem_op=MEM_READ; writes commit on the clock edge ending the cycle with mem_op=MEM_WRITE.

Function
REQ-010 SHALL implement states IDLE, LOAD, STORE, COPY_RD, COPY_WR, FILL, DONE.
REQ-011 SHALL assert req_ready only in IDLE; req_valid in any other state is ignored and not queued.
REQ-012 SHALL on accepted request latch all req_* fields and go to LOAD, STORE, COPY_RD (len>0) or FILL (len>0); COPY/FILL with len=0 go directly to DONE with no memory access.
REQ-013 SHALL drive mem_op=MEM_NOP, mem_addr=0, mem_write_data=0 in IDLE and DONE.
REQ-014 LOAD: one cycle, mem_op=MEM_READ, mem_addr=addr; capture mem_read_data into result; go to DONE.
REQ-015 STORE: one cycle, mem_op=MEM_WRITE, mem_addr=addr, mem_write_data=data; result=0; go to DONE.
REQ-016 COPY: per word i, COPY_RD drives MEM_READ at src+i and latches data into a one-word buffer; COPY_WR drives MEM_WRITE at addr+i with buffer; 2 cycles/word; after word len-1 go to DONE; result=len.
REQ-017 FILL: one cycle per word, MEM_WRITE at addr+i with data; after len words go to DONE; result=len.
REQ-018 SHALL compute all addresses modulo 2^WORD_SIZE (wrap 255 -> 0 at WORD_SIZE=8).
REQ-019 SHALL pulse resp_valid for exactly the one DONE cycle with resp_data=result, then return to IDLE; resp_data SHALL be 0 when resp_valid is low.
REQ-020 Latency accept-edge to resp_valid: LOAD/STORE 2 cycles, COPY 2*len+1, FILL len+1, len=0 1 cycle.
REQ-021 Overlapping source/destination in COPY SHALL be copied ascending, word by word, with no hazard protection.

Reset
REQ-022 While reset is low at a rising edge: state=IDLE, counters, buffer and result cleared; next cycle req_ready=1, busy=0, resp_valid=0, mem_op=MEM_NOP.
REQ-023 Reset mid-operation SHALL abort; no memory write SHALL be issued after the reset edge and no resp_valid for the aborted request.

Structure
REQ-024 MEM_NOP/MEM_READ/MEM_WRITE encodings, req_kind enum and WORD_SIZE SHALL live in package instruction_set, shared with the data-memory responder.
REQ-025 SHALL be a single module, no sub-modules; state as an enum typedef local to the module.

Verification (WORD_SIZE=8, bench models responder memory)
REQ-026 LOAD addr=0x10 with mem[0x10]=0x5A -> MEM_READ@0x10 next cycle, resp_valid one cycle later, resp_data=0x5A.
REQ-027 FILL addr=0xFE len=3 data=0xAA -> writes 0xFE,0xFF,0x00 = 0xAA over 3 cycles, resp_data=3 at cycle 4.
REQ-028 COPY src=0x20 dst=0x40 len=4, mem[0x20..0x23]=1,2,3,4 -> mem[0x40..0x43]=1,2,3,4, resp at cycle 9, resp_data=4.
REQ-029 COPY len=0 -> no mem_op other than MEM_NOP, resp_valid next cycle, resp_data=0.
REQ-030 Second req_valid held during busy COPY -> not accepted until cycle after DONE; then accepted exactly once.
REQ-031 Reset low after 2nd word of FILL len=5 -> only 2 words written, no resp_valid, req_ready=1 next cycle.
